// File: rtl/m68k_bus_master.sv
// rtl/m68k_bus_master.sv - single-outstanding 68000-style asynchronous bus master.
// DTACK/BERR are synchronized; the bus cycle is sequenced by a six-state FSM.
module m68k_bus_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_ADDR,
  input  logic [15:0] REQ_WDATA,
  input  logic [1:0]  REQ_BE,
  output logic        ACK,
  output logic [15:0] RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic [22:0] ADDR_OUT,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [15:0] DATA_IN,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic        DTACK,
  input  logic        BERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_STROBE, S_WAIT, S_END, S_RECOVER
  } state_t;

  state_t      state, state_nx;
  logic        dtk_m, dtk_s, berr_m, berr_s;
  logic        cmd_rw;
  logic [1:0]  cmd_be;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        err_q;
  logic        rej_q;
  logic [CW-1:0] cnt;
  logic        accept, reject, timeout, strobe_on;

  assign accept  = (state == S_IDLE) && REQ && (REQ_BE != 2'b00);
  assign reject  = (state == S_IDLE) && REQ && (REQ_BE == 2'b00);
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (accept) state_nx = S_ADDR;
      S_ADDR:    state_nx = S_STROBE;
      S_STROBE:  state_nx = S_WAIT;
      S_WAIT:    if (!berr_s || !dtk_s || timeout) state_nx = S_END;
      S_END:     state_nx = S_RECOVER;
      S_RECOVER: if (dtk_s && berr_s) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // BERR outranks DTACK, so a simultaneous pair never updates RDATA
  always_ff @(posedge CLK) begin
    if (RST) begin
      dtk_m   <= 1'b1;
      dtk_s   <= 1'b1;
      berr_m  <= 1'b1;
      berr_s  <= 1'b1;
      cmd_rw  <= 1'b1;
      cmd_be  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      dtk_m  <= DTACK;
      dtk_s  <= dtk_m;
      berr_m <= BERR;
      berr_s <= berr_m;
      rej_q  <= reject;
      if (accept) begin
        cmd_rw <= REQ_RW;
        cmd_be <= REQ_BE;
        addr_q <= REQ_ADDR;
        if (!REQ_RW) wdata_q <= REQ_WDATA;
      end
      if (state == S_STROBE)    cnt <= '0;
      else if (state == S_WAIT) cnt <= cnt + CW'(1);
      if (state == S_WAIT) begin
        if (!berr_s) begin
          err_q <= 1'b1;
        end else if (!dtk_s) begin
          err_q <= 1'b0;
          if (cmd_rw) rdata_q <= DATA_IN;
        end else if (timeout) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    strobe_on = ((state == S_STROBE) && cmd_rw) || (state == S_WAIT);
    AS        = !((state == S_STROBE) || (state == S_WAIT));
    UDS       = !(strobe_on && cmd_be[1]);
    LDS       = !(strobe_on && cmd_be[0]);
    RW        = (state == S_IDLE) ? 1'b1 : cmd_rw;
    DATA_OE   = !cmd_rw && ((state == S_ADDR) || (state == S_STROBE) || (state == S_WAIT));
    ACK       = (state == S_END) || rej_q;
    ERR       = ((state == S_END) && err_q) || rej_q;
    BUSY      = (state != S_IDLE);
    ADDR_OUT  = addr_q;
    DATA_OUT  = wdata_q;
    RDATA     = rdata_q;
  end

endmodule

// File: doc/m68k_bus_master.md
M68K_BUS_MASTER -- requirements
Module: m68k_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: WAIT-state cycles before a bus cycle aborts with error.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  system clock; all logic on posedge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 REQ  in  1  command request; sampled only in IDLE.
REQ-006 REQ_RW  in  1  1=read, 0=write.
REQ-007 REQ_ADDR  in  23  word address [23:1].
REQ-008 REQ_WDATA  in  16  write data.
REQ-009 REQ_BE  in  2  byte enables, [1]=upper (UDS), [0]=lower (LDS).
REQ-010 ACK  out  1  one-cycle completion pulse.
REQ-011 RDATA  out  16  read data, valid with ACK, held until next read completes.
REQ-012 ERR  out  1  valid with ACK; 1=cycle ended in bus error/timeout/reject.
REQ-013 BUSY  out  1  high from the cycle after REQ is accepted until the cycle after ACK.
REQ-014 ADDR_OUT  out  23  bus address.
REQ-015 DATA_OUT  out  16  bus write data; DATA_OE  out  1  write-data drive enable.
REQ-016 DATA_IN  in  16  bus read data.
REQ-017 AS, UDS, LDS, RW  out  1 each  active-low strobes; RW 1=read.
REQ-018 DTACK, BERR  in  1 each  active-low, asynchronous to CLK.

Function
REQ-019 DTACK and BERR pass through two-flop synchronizers; all decisions use synchronized values (DTK_S, BERR_S).
REQ-020 States: IDLE, ADDR, STROBE, WAIT, END, RECOVER.
REQ-021 IDLE: REQ=1 with REQ_BE!=00 latches command, -> ADDR; REQ=1 with REQ_BE=00 -> no bus activity, ACK=1 and ERR=1 on the next cycle, -> IDLE.
REQ-022 ADDR (1 cycle): ADDR_OUT, RW from latched command; writes drive DATA_OUT and set DATA_OE=1; AS/UDS/LDS stay high; -> STROBE.
REQ-023 STROBE (1 cycle): AS=0; reads also assert UDS=~BE[1], LDS=~BE[0]; -> WAIT.
REQ-024 WAIT: writes assert UDS/LDS per BE on entry; timeout counter clears on entry, increments each WAIT cycle.
REQ-025 WAIT exit priority: BERR_S=0 -> END with error; else DTK_S=0 -> END (reads latch DATA_IN into RDATA on that edge); else counter=TIMEOUT_CYCLES-1 -> END with error.
REQ-026 END (1 cycle): AS, UDS, LDS=1; ACK=1; ERR per REQ-025; DATA_OE=0; ADDR_OUT/RW held; -> RECOVER.
REQ-027 RECOVER: stay until DTK_S=1 and BERR_S=1, then -> IDLE; RW returns to 1 in IDLE.
REQ-028 Simultaneous DTACK and BERR: BERR wins; RDATA not updated.
REQ-029 Errored reads do not modify RDATA.
REQ-030 REQ ignored outside IDLE; no queueing.
REQ-031 Minimum bus cycle (DTACK already low at STROBE): ACK 5 cycles after REQ acceptance (2 synchronizer cycles included).

Reset
REQ-032 RST=1 at a clock edge, in any state: next state IDLE; AS=UDS=LDS=RW=1, DATA_OE=0, ACK=0, ERR=0, BUSY=0, ADDR_OUT=0, DATA_OUT=0, RDATA=0, counter=0, synchronizers=1.
REQ-033 Reset mid-cycle releases all strobes on that edge; no ACK for the aborted cycle.

Verification
REQ-034 Read, REQ_ADDR=0x000100, BE=11, DTACK low after AS -> UDS=LDS=0 with AS, RDATA=DATA_IN=0xBEEF, ACK=1 ERR=0.
REQ-035 Write, BE=01, WDATA=0x1234 -> LDS=0 one cycle after AS, UDS=1, DATA_OE=1 until END, ACK ERR=0.
REQ-036 No DTACK, TIMEOUT_CYCLES=8 -> END after 8 WAIT cycles, ACK=1 ERR=1, strobes high.
REQ-037 DTACK and BERR low same cycle on read -> ERR=1, RDATA unchanged; DTACK held low 10 cycles -> stays in RECOVER, BUSY=1.
REQ-038 REQ with BE=00 -> ACK=1 ERR=1 next cycle, AS never asserted.
REQ-039 RST=1 while in WAIT -> strobes high next edge, no ACK, new REQ accepted after RST=0.
